// File: rtl/level_sync_mc_pkg.sv
// Shared types and helpers for the multi-lane level synchroniser.
package level_sync_pkg;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic POL_BELOW_START = 1'b0;
  localparam logic POL_ABOVE_START = 1'b1;

  // Widest counter the saturating helper supports.
  localparam int unsigned SAT_MAX_W = 64;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                  input int unsigned width);
    logic [SAT_MAX_W-1:0] max_val;
    max_val = (width >= SAT_MAX_W) ? '1
                                   : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    return (value >= max_val) ? max_val : value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/level_sync_mc_if.sv
// Sample, configuration and status bundle of level_sync_mc.
// LEVEL_SYNC_MC_MAXLEN_EN adds max_len / timeout.
interface level_sync_mc_if #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned CNT_W    = 32
);
  logic                      enable;
  logic [LANES*SAMPLE_W-1:0] adc_data;
  logic                      adc_valid;
  logic                      polarity;
  logic                      consec_mode;
  logic [SAMPLE_W-1:0]       start_threshold;
  logic [SAMPLE_W-1:0]       stop_threshold;
  logic [CNT_W-1:0]          start_count;
  logic [CNT_W-1:0]          stop_count;
  logic                      sync;
  logic                      sync_start;
  logic                      sync_stop;
  logic [CNT_W-1:0]          beat_count;
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
  logic [CNT_W-1:0]          max_len;
  logic                      timeout;
`endif

  modport master (
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
    output max_len,
    input  timeout,
`endif
    output enable, adc_data, adc_valid, polarity, consec_mode,
    output start_threshold, stop_threshold, start_count, stop_count,
    input  sync, sync_start, sync_stop, beat_count
  );

  modport slave (
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
    input  max_len,
    output timeout,
`endif
    input  enable, adc_data, adc_valid, polarity, consec_mode,
    input  start_threshold, stop_threshold, start_count, stop_count,
    output sync, sync_start, sync_stop, beat_count
  );

endinterface

// File: rtl/level_sync_qualify.sv
// Per-beat qualifier: valid and every lane strictly beyond the threshold.
module level_sync_qualify #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic [LANES*SAMPLE_W-1:0] adc_data,
  input  logic                      adc_valid,
  input  logic [SAMPLE_W-1:0]       threshold,
  input  logic                      above,
  output logic                      qualify
);

  logic [LANES-1:0] lane_ok;

  // Strict compare per lane; equality never qualifies.
  always_comb begin
    lane_ok = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_ok[i] = above ? (adc_data[i*SAMPLE_W +: SAMPLE_W] > threshold)
                         : (adc_data[i*SAMPLE_W +: SAMPLE_W] < threshold);
    end
  end

  assign qualify = adc_valid & (&lane_ok);

endmodule

// File: rtl/level_sync_mc.sv
// Multi-lane ADC level synchroniser: raises sync after start_count qualifying
// beats, drops it after stop_count. LEVEL_SYNC_MC_MAXLEN_EN bounds sync length.
module level_sync_mc
  import level_sync_pkg::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic            clk,
  input  logic            resetn,
  level_sync_mc_if.slave  bus
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc, n_raw, n_eff;
  logic                sync_q, sync_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic [SAMPLE_W-1:0] thr;
  logic                above;
  logic                qual;
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
  logic [CNT_W-1:0]    len_q, len_d, len_inc;
  logic                timeout_q, timeout_d;
`endif

  // IDLE looks for the start level, ACTIVE for the opposite-sense stop level.
  assign thr   = (state_q == S_IDLE) ? bus.start_threshold : bus.stop_threshold;
  assign above = (state_q == S_IDLE) ? (bus.polarity == POL_ABOVE_START)
                                     : (bus.polarity == POL_BELOW_START);

  level_sync_qualify #(
    .LANES    (LANES),
    .SAMPLE_W (SAMPLE_W)
  ) u_qualify (
    .adc_data  (bus.adc_data),
    .adc_valid (bus.adc_valid),
    .threshold (thr),
    .above     (above),
    .qualify   (qual)
  );

  assign cnt_inc = CNT_W'(sat_inc(SAT_MAX_W'(cnt_q), CNT_W));
  assign n_raw   = (state_q == S_IDLE) ? bus.start_count : bus.stop_count;
  assign n_eff   = (n_raw == '0) ? CNT_W'(1) : n_raw;
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
  assign len_inc = CNT_W'(sat_inc(SAT_MAX_W'(len_q), CNT_W));
`endif

  // Next state, counters and event pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
    len_d     = len_q;
    timeout_d = 1'b0;
`endif
    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      stop_d  = (state_q == S_ACTIVE);
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
      len_d   = '0;
`endif
    end else if (bus.adc_valid) begin
      if (qual) begin
        if (cnt_inc >= n_eff) begin
          cnt_d = '0;
          if (state_q == S_IDLE) begin
            state_d = S_ACTIVE;
            start_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            stop_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (bus.consec_mode) begin
        cnt_d = '0;
      end
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
      // A normal stop on the same beat takes precedence over the length limit.
      if (state_q == S_ACTIVE) begin
        if (stop_d) begin
          len_d = '0;
        end else if ((bus.max_len != '0) && (len_inc >= bus.max_len)) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          len_d     = '0;
          stop_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          len_d = len_inc;
        end
      end
`endif
    end
    sync_d = (state_d == S_ACTIVE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sync_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
      len_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      start_q <= start_d;
      stop_q  <= stop_d;
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
      len_q     <= len_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.sync       = sync_q;
  assign bus.sync_start = start_q;
  assign bus.sync_stop  = stop_q;
  assign bus.beat_count = cnt_q;
`ifdef LEVEL_SYNC_MC_MAXLEN_EN
  assign bus.timeout    = timeout_q;
`endif

endmodule
